// File: rtl/radar_emulator.sv
`default_nettype none
// ============================================================================
// Module   : radar_emulator
// Purpose  : Target-scenario generator standing in for the three radar sector
//            switches. Presents one target at a time in an LFSR-chosen sector,
//            holds it for a dwell window and scores a hit (armed fire rising
//            edge) or a miss (window expiry), separated by empty-radar gaps.
// Ports    : i_clock         system clock, rising edge
//            i_reset         asynchronous active-high reset
//            i_enable        level, high runs the scenario, low parks in IDLE
//            i_fire          level fire button, rising edge used
//            i_armed         level armed switch, qualifies fire
//            o_radar_1..3    registered one-hot (or zero) sector lines
//            o_target_active OR of the sector lines
//            o_hit_pulse     one-cycle pulse after a scored hit
//            o_miss_pulse    one-cycle pulse after a dwell expiry
//            o_hits          saturating hit count (0..31)
//            o_misses        saturating miss count (0..31)
// Revision : 1.0  initial release
// ============================================================================
module radar_emulator #(
  parameter int         DWELL_CYCLES = 50_000_000,
  parameter int         GAP_CYCLES   = 25_000_000,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_fire,
  input  logic       i_armed,
  output logic       o_radar_1,
  output logic       o_radar_2,
  output logic       o_radar_3,
  output logic       o_target_active,
  output logic       o_hit_pulse,
  output logic       o_miss_pulse,
  output logic [4:0] o_hits,
  output logic [4:0] o_misses
);

  // An all-zero LFSR would lock up, so that seed is remapped.
  localparam logic [7:0] c_seed    = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam int         c_max_cnt = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  // Counter only ever holds load values of (N-1), so clog2(N) bits suffice.
  localparam int         c_cnt_w   = (c_max_cnt > 1) ? $clog2(c_max_cnt) : 1;

  localparam logic [c_cnt_w-1:0] c_gap_load   = c_cnt_w'(GAP_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_dwell_load = c_cnt_w'(DWELL_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
  localparam logic [4:0]         c_count_max  = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GAP   = 2'd1,
    S_TRACK = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_n;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_n;
  logic [2:0]         r_radar;
  logic [2:0]         w_radar_n;
  logic [4:0]         r_hits;
  logic [4:0]         w_hits_n;
  logic [4:0]         r_misses;
  logic [4:0]         w_misses_n;
  logic               r_hit_pulse;
  logic               w_hit_pulse_n;
  logic               r_miss_pulse;
  logic               w_miss_pulse_n;
  logic [7:0]         r_lfsr;
  logic               r_fire_q;
  logic               w_fire_edge;
  logic [2:0]         w_sector;

  assign w_fire_edge = i_fire & ~r_fire_q;

  // Sector decode from the low LFSR bits; code 3 folds onto sector 1.
  always_comb begin
    w_sector = 3'b001;
    case (r_lfsr[1:0])
      2'd1:    w_sector = 3'b010;
      2'd2:    w_sector = 3'b100;
      default: w_sector = 3'b001;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_radar      <= 3'b000;
      r_hits       <= 5'd0;
      r_misses     <= 5'd0;
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
      r_lfsr       <= c_seed;
      r_fire_q     <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_cnt        <= w_cnt_n;
      r_radar      <= w_radar_n;
      r_hits       <= w_hits_n;
      r_misses     <= w_misses_n;
      r_hit_pulse  <= w_hit_pulse_n;
      r_miss_pulse <= w_miss_pulse_n;
      r_lfsr       <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      r_fire_q     <= i_fire;
    end
  end

  always_comb begin
    w_state_n      = r_state;
    w_cnt_n        = r_cnt;
    w_radar_n      = r_radar;
    w_hits_n       = r_hits;
    w_misses_n     = r_misses;
    w_hit_pulse_n  = 1'b0;
    w_miss_pulse_n = 1'b0;

    if (!i_enable) begin
      // Dropping enable overrides any hit or expiry at the same edge.
      w_state_n = S_IDLE;
      w_radar_n = 3'b000;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_n = S_GAP;
          w_cnt_n   = c_gap_load;
          w_radar_n = 3'b000;
        end
        S_GAP: begin
          w_radar_n = 3'b000;
          if (r_cnt == '0) begin
            w_state_n = S_TRACK;
            w_cnt_n   = c_dwell_load;
            w_radar_n = w_sector;
          end else begin
            w_cnt_n = r_cnt - c_cnt_one;
          end
        end
        S_TRACK: begin
          // Hit is tested first so it wins over a coincident expiry.
          if (w_fire_edge && i_armed) begin
            w_state_n     = S_GAP;
            w_cnt_n       = c_gap_load;
            w_radar_n     = 3'b000;
            w_hit_pulse_n = 1'b1;
            if (r_hits != c_count_max) begin
              w_hits_n = r_hits + 5'd1;
            end
          end else if (r_cnt == '0) begin
            w_state_n      = S_GAP;
            w_cnt_n        = c_gap_load;
            w_radar_n      = 3'b000;
            w_miss_pulse_n = 1'b1;
            if (r_misses != c_count_max) begin
              w_misses_n = r_misses + 5'd1;
            end
          end else begin
            w_cnt_n = r_cnt - c_cnt_one;
          end
        end
        default: begin
          w_state_n = S_IDLE;
          w_radar_n = 3'b000;
        end
      endcase
    end
  end

  assign o_radar_1       = r_radar[0];
  assign o_radar_2       = r_radar[1];
  assign o_radar_3       = r_radar[2];
  assign o_target_active = |r_radar;
  assign o_hit_pulse     = r_hit_pulse;
  assign o_miss_pulse    = r_miss_pulse;
  assign o_hits          = r_hits;
  assign o_misses        = r_misses;

endmodule
`default_nettype wire
